// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among NUM_REQ requesters.
// Latches the winning command, waits for m_done or timeout, and routes the response back.
module i2c_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   m_start,
  output logic                   m_rw,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_wdata,
  output logic                   m_abort,
  input  logic                   m_done,
  input  logic                   m_ack,
  input  logic [7:0]             m_rdata,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   grant_idx, cand;
  logic               grant_found;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_hit;

  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [7:0]         rsp_rdata_d, m_wdata_d;
  logic [6:0]         m_addr_d;
  logic               rsp_err_d, m_rw_d, m_start_d, busy_d;

  // First pending requester searching upward (with wrap) from last_grant+1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_q;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign timeout_hit = (cnt_q == TIMEOUT - 16'd1);

  // Abort must be suppressed by an m_done arriving in the match cycle itself
  assign m_abort = (state_q == S_WAIT) && !m_done && timeout_hit;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    m_rw_d      = m_rw;
    m_addr_d    = m_addr;
    m_wdata_d   = m_wdata;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    req_ready_d = '0;
    rsp_valid_d = '0;
    m_start_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          win_d       = grant_idx;
          m_rw_d      = req_rw[grant_idx];
          m_addr_d    = req_addr[7*32'(grant_idx) +: 7];
          m_wdata_d   = req_wdata[8*32'(grant_idx) +: 8];
          m_start_d   = 1'b1;
          req_ready_d = ONE << grant_idx;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) begin
          rsp_rdata_d = m_rw ? m_rdata : 8'h00;
          rsp_err_d   = ~m_ack;
          rsp_valid_d = ONE << win_q;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
          rsp_valid_d = ONE << win_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      win_q     <= '0;
      cnt_q     <= '0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      m_start   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      m_rw      <= m_rw_d;
      m_addr    <= m_addr_d;
      m_wdata   <= m_wdata_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      m_start   <= m_start_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: a round-robin reference model predicts each grant and
// its response; a separate monitor pops expectations whenever the arbiter responds.
module tb_i2c_arbiter;

  localparam int NR = 4;
  localparam int TO = 8;

  logic            clk, rst;
  logic [NR-1:0]   req_valid, req_rw, req_ready, rsp_valid;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [7:0]      rsp_rdata, m_wdata, m_rdata;
  logic            rsp_err, m_start, m_rw, m_abort, m_ack, busy;
  logic [6:0]      m_addr;
  logic            m_done = 1'b0;

  i2c_arbiter #(.NUM_REQ(NR), .TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_abort(m_abort),
    .m_done(m_done), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int delay; bit ack; logic [7:0] rdata; } plan_t;
  typedef struct { int w; logic [7:0] rdata; bit err; longint rsp_cyc; longint abort_cyc; } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    grant_log[$];

  logic [NR-1:0] v, rw;
  logic [6:0]    ad [NR];
  logic [7:0]    wd [NR];
  bit            rand_en = 0, repost = 0, spur_en = 0;

  always_comb begin
    req_valid = v;
    req_rw    = rw;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[7*i +: 7]  = ad[i];
      req_wdata[8*i +: 8] = wd[i];
    end
  end

  int     vectors = 0, miscompares = 0;
  longint cyc = 0;
  logic [NR-1:0] vld_at_edge = '0;
  logic          rst_at_edge = 1'b1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int r = $urandom_range(0, 9);
    p.ack   = ($urandom_range(0, 4) != 0);
    p.rdata = 8'($urandom);
    if (r == 0)      p.delay = 0;
    else if (r == 1) p.delay = TO;
    else             p.delay = $urandom_range(1, TO - 1);
    return p;
  endfunction

  // What the arbiter saw at each active edge
  always @(posedge clk) begin
    cyc++;
    vld_at_edge = req_valid;
    rst_at_edge = rst;
  end

  // Reference model: IDLE/busy tracking, round-robin grant prediction, response prediction
  bit     idle = 1, pend = 0;
  int     last_win = NR - 1;
  longint cur_rsp = -1, end_cyc = 0, done_cyc = -1;
  bit     d_ack = 0;
  logic [7:0] d_rdata = '0;

  always @(negedge clk) begin : issue_side
    bit grant, idle_now, done_ok;
    int ew;
    plan_t p;
    exp_t e;
    if (rst) begin
      idle = 1; last_win = NR - 1; cur_rsp = -1; pend = 0;
    end else begin
      if (pend && cyc >= end_cyc) pend = 0;
      grant    = idle && (vld_at_edge != '0) && !rst_at_edge;
      idle_now = (idle && !grant) || (cur_rsp == cyc - 1);
      chk("m_start", 32'(m_start), 32'(grant));
      chk("busy", 32'(busy), 32'(!idle_now));
      idle = idle_now;
      if (m_start) begin
        ew = -1;
        for (int i = 1; i <= NR; i++)
          if (ew < 0 && vld_at_edge[(last_win + i) % NR]) ew = (last_win + i) % NR;
        if (ew >= 0) begin
          chk("req_ready", 32'(req_ready), 32'(1) << ew);
          chk("m_rw", 32'(m_rw), 32'(rw[ew]));
          chk("m_addr", 32'(m_addr), 32'(ad[ew]));
          chk("m_wdata", 32'(m_wdata), 32'(wd[ew]));
          last_win = ew;
          grant_log.push_back(ew);
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else                   p = rand_plan();
          done_ok     = (p.delay >= 1) && (p.delay <= TO);
          e.w         = ew;
          e.rdata     = (done_ok && rw[ew]) ? p.rdata : 8'h00;
          e.err       = done_ok ? !p.ack : 1'b1;
          e.rsp_cyc   = cyc + (done_ok ? p.delay : TO) + 1;
          e.abort_cyc = done_ok ? -1 : cyc + TO;
          exp_q.push_back(e);
          cur_rsp  = e.rsp_cyc;
          pend     = 1;
          end_cyc  = done_ok ? cyc + p.delay : cyc + TO;
          done_cyc = done_ok ? cyc + p.delay : -1;
          d_ack    = p.ack;
          d_rdata  = p.rdata;
        end
      end
    end
  end

  // I2C master model: completion pulses, plus optional spurious pulses while nothing is outstanding
  always @(posedge clk) begin
    #1;
    if (pend && cyc == done_cyc) begin
      m_done = 1'b1; m_ack = d_ack; m_rdata = d_rdata;
    end else if (spur_en && !pend && $urandom_range(0, 5) == 0) begin
      m_done = 1'b1; m_ack = 1'($urandom); m_rdata = 8'($urandom);
    end else begin
      m_done = 1'b0; m_ack = 1'($urandom); m_rdata = 8'($urandom);
    end
  end

  // Response monitor
  always @(negedge clk) begin : rsp_side
    exp_t e;
    bit due, ab;
    if (rst) begin
      exp_q.delete();
    end else begin
      ab = (exp_q.size() > 0) && (exp_q[0].abort_cyc == cyc);
      if (m_abort || ab) chk("m_abort", 32'(m_abort), 32'(ab));
      while (exp_q.size() > 0 && exp_q[0].rsp_cyc < cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missed_cycle", 32'(cyc), 32'(e.rsp_cyc));
      end
      due = (exp_q.size() > 0) && (exp_q[0].rsp_cyc == cyc);
      if (rsp_valid != '0 || due) begin
        if (exp_q.size() == 0) begin
          chk("rsp_valid_spurious", 32'(rsp_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.w);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.rsp_cyc));
        end
      end
    end
  end

  task automatic post(int i, bit r, logic [6:0] a, logic [7:0] d);
    v[i] = 1'b1; rw[i] = r; ad[i] = a; wd[i] = d;
  endtask

  task automatic post_rand(int i);
    post(i, 1'($urandom), 7'($urandom), 8'($urandom));
  endtask

  // One clock: requesters drop valid after the edge that closed their accept cycle
  task automatic step();
    logic [NR-1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (rdy[i]) begin
        v[i] = 1'b0;
        if (repost) post_rand(i);
      end
    if (rand_en)
      for (int i = 0; i < NR; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) post_rand(i);
  endtask

  task automatic wait_idle(int n);
    int k = 0;
    while (k < n && !(v == '0 && exp_q.size() == 0 && !busy)) begin
      step();
      k++;
    end
    if (!(v == '0 && exp_q.size() == 0 && !busy)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles, %0d responses outstanding", n, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_m_start"},   32'(m_start),   32'(0));
    chk({tag, "_m_abort"},   32'(m_abort),   32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'(0));
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(0));
    chk({tag, "_m_rw"},      32'(m_rw),      32'(0));
    chk({tag, "_m_addr"},    32'(m_addr),    32'(0));
    chk({tag, "_m_wdata"},   32'(m_wdata),   32'(0));
  endtask

  task automatic do_reset(string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v   = '0;
    rw  = '0;
    for (int i = 0; i < NR; i++) begin ad[i] = '0; wd[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Single write from requester 2
    post(2, 1'b0, 7'h50, 8'hA5);
    plan_q.push_back('{6, 1'b1, 8'h3C});
    wait_idle(60);

    // Read from requester 1 at minimum latency
    post(1, 1'b1, 7'h3C, 8'h00);
    plan_q.push_back('{1, 1'b1, 8'h5A});
    wait_idle(60);

    // Fairness with all requesters continuously valid
    do_reset("rst_idle");
    grant_log.delete();
    repost = 1;
    for (int i = 0; i < NR; i++) post_rand(i);
    for (int k = 0; k < 400 && grant_log.size() < 8; k++) step();
    repost = 0;
    wait_idle(300);
    for (int k = 0; k < 8; k++)
      chk("grant_order", (grant_log.size() > k) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(k % NR));

    // NACK, pure timeout, and m_done exactly on the timeout cycle
    post(3, 1'b1, 7'h21, 8'h00);
    plan_q.push_back('{3, 1'b0, 8'h99});
    wait_idle(60);
    post(0, 1'b1, 7'h11, 8'h00);
    plan_q.push_back('{0, 1'b1, 8'hEE});
    wait_idle(60);
    post(2, 1'b1, 7'h12, 8'h00);
    plan_q.push_back('{TO, 1'b1, 8'h44});
    wait_idle(60);
    post(2, 1'b0, 7'h13, 8'h77);
    plan_q.push_back('{TO, 1'b0, 8'h66});
    wait_idle(60);

    // Reset mid-WAIT with requesters 3 and 0 pending
    post(1, 1'b1, 7'h33, 8'h00);
    plan_q.push_back('{0, 1'b1, 8'h00});
    repeat (4) step();
    post(3, 1'b0, 7'h03, 8'h30);
    post(0, 1'b1, 7'h04, 8'h40);
    repeat (2) step();
    do_reset("rst_wait");
    grant_log.delete();
    wait_idle(100);
    chk("post_reset_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'(0));
    chk("post_reset_second", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFF_FFFF, 32'(3));

    // Spurious m_done while idle; requester 1 drops valid right after its accept
    spur_en = 1;
    repeat (20) step();
    post(1, 1'b1, 7'h2A, 8'h5C);
    plan_q.push_back('{5, 1'b1, 8'hC3});
    wait_idle(60);
    repeat (10) step();

    // Randomized traffic
    rand_en = 1;
    repeat (1500) step();
    rand_en = 0;
    wait_idle(400);
    spur_en = 0;
    repeat (4) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
